// File: rtl/systolic_ctrl.sv
// Job sequencer for the weight-stationary systolic array: kernel load, settle gap, execute, drain, done pulse.
// Optional performance counters are built when SYS_CTRL_PERF_EN is defined.
module systolic_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] a_base,
  output logic               mem_cen,
  output logic [addr_bw-1:0] mem_addr,
  output logic [1:0]         inst_w,
  output logic               busy,
  output logic               done
`ifdef SYS_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_cycles,
  output logic [15:0]        perf_jobs
`endif
);

  localparam int DRAIN_BW = $clog2(row + col + 1);
  localparam int CW       = (len_bw > DRAIN_BW) ? len_bw : DRAIN_BW;

  localparam logic [CW-1:0] COL_LAST   = CW'(col - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(row + col - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GAP,
    EXEC,
    DRAIN,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [len_bw-1:0]  len_q;
  logic [addr_bw-1:0] w_base_q, a_base_q;
  logic [1:0]         inst_pre, inst_pre_nxt;
  logic               mem_cen_nxt;
  logic [addr_bw-1:0] mem_addr_nxt;
  logic [addr_bw-1:0] w_sel;
  logic [CW-1:0]      len_last;
  logic               accept;

  assign accept   = (state == IDLE) && start;
  assign len_last = CW'(len_q) - CW'(1);
  // On the accept cycle the weight base is not latched yet, so use the live input.
  assign w_sel    = accept ? w_base : w_base_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt   = '0;
          state_nxt = (len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (cnt == COL_LAST) begin
          cnt_nxt   = '0;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == COL_LAST) begin
          cnt_nxt   = '0;
          state_nxt = EXEC;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      EXEC: begin
        if (cnt == len_last) begin
          cnt_nxt   = '0;
          state_nxt = DRAIN;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Request stage is computed from the next state so the pins track the state register.
  always_comb begin
    mem_cen_nxt  = 1'b1;
    mem_addr_nxt = mem_addr;
    inst_pre_nxt = 2'b00;
    case (state_nxt)
      LOAD: begin
        mem_cen_nxt  = 1'b0;
        mem_addr_nxt = w_sel + addr_bw'(cnt_nxt);
        inst_pre_nxt = 2'b01;
      end
      EXEC: begin
        mem_cen_nxt  = 1'b0;
        mem_addr_nxt = a_base_q + addr_bw'(cnt_nxt);
        inst_pre_nxt = 2'b10;
      end
      default: begin
        mem_cen_nxt  = 1'b1;
        inst_pre_nxt = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      len_q    <= '0;
      w_base_q <= '0;
      a_base_q <= '0;
      mem_cen  <= 1'b1;
      mem_addr <= '0;
      inst_pre <= 2'b00;
      inst_w   <= 2'b00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mem_cen  <= mem_cen_nxt;
      mem_addr <= mem_addr_nxt;
      inst_pre <= inst_pre_nxt;
      // One extra stage so the instruction lines up with SRAM read data.
      inst_w   <= inst_pre;
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
      if (accept) begin
        len_q    <= len;
        w_base_q <= w_base;
        a_base_q <= a_base;
      end
    end
  end

`ifdef SYS_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_jobs   <= '0;
    end else begin
      if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      if (done) begin
        perf_jobs <= perf_jobs + 16'd1;
      end
    end
  end
`else
  // Performance counters are not present in this build.
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: per-cycle comparison against a phase-timeline reference model.
module tb_systolic_ctrl;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int ABW = 11;
  localparam int LBW = 8;

  typedef struct packed {
    logic           cen;
    logic [ABW-1:0] addr;
    logic [1:0]     inst;
    logic           busy;
    logic           done;
  } obs_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [LBW-1:0] len = '0;
  logic [ABW-1:0] w_base = '0;
  logic [ABW-1:0] a_base = '0;
  logic           mem_cen;
  logic [ABW-1:0] mem_addr;
  logic [1:0]     inst_w;
  logic           busy;
  logic           done;
`ifdef SYS_CTRL_PERF_EN
  logic [31:0]    perf_cycles;
  logic [15:0]    perf_jobs;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  systolic_ctrl #(.row(ROW), .col(COL), .addr_bw(ABW), .len_bw(LBW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .w_base(w_base), .a_base(a_base),
    .mem_cen(mem_cen), .mem_addr(mem_addr), .inst_w(inst_w), .busy(busy), .done(done)
`ifdef SYS_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_jobs(perf_jobs)
`endif
  );

  // Reference timeline: cycle 0 is the accept cycle, t counts cycles after it.
  function automatic int job_len(int L);
    return (L == 0) ? 1 : 1 + COL + COL + L + ROW + COL;
  endfunction

  function automatic logic [1:0] pre_at(int t, int L);
    if (L == 0) return 2'b00;
    if (t >= 1 && t <= COL) return 2'b01;
    if (t > 2*COL && t <= 2*COL + L) return 2'b10;
    return 2'b00;
  endfunction

  function automatic obs_t model(int t, int L, logic [ABW-1:0] w, logic [ABW-1:0] a);
    obs_t o;
    logic [1:0] p;
    p = pre_at(t, L);
    o.cen  = (p == 2'b00);
    o.addr = (p == 2'b01) ? w + ABW'(t - 1) : a + ABW'(t - 2*COL - 1);
    o.inst = pre_at(t - 1, L);
    o.busy = (t >= 1 && t <= job_len(L));
    o.done = (t == job_len(L));
    return o;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_cen, mem_addr, inst_w, busy, done} !== {1'b1, {ABW{1'b0}}, 2'b00, 1'b0, 1'b0})
      begin
        failures++;
        $display("FAIL reset_state got cen=%b addr=%h inst=%b busy=%b done=%b want 1 000 00 0 0",
                 mem_cen, mem_addr, inst_w, busy, done);
      end
    reset = 1'b0;
  endtask

  task automatic test_basic(input string tag, input int L, input logic [ABW-1:0] w,
                            input logic [ABW-1:0] a);
    obs_t e;
    @(negedge clk);
    len = LBW'(L); w_base = w; a_base = a; start = 1'b1;
    for (int t = 1; t <= job_len(L) + 1; t++) begin
      @(negedge clk);
      start = 1'b0;
      e = model(t, L, w, a);
      checks++;
      if ({mem_cen, inst_w, busy, done} !== {e.cen, e.inst, e.busy, e.done}) begin
        failures++;
        $display("FAIL %s_ctl t=%0d got cen=%b inst=%b busy=%b done=%b want %b %b %b %b",
                 tag, t, mem_cen, inst_w, busy, done, e.cen, e.inst, e.busy, e.done);
      end
      if (!e.cen) begin
        checks++;
        if (mem_addr !== e.addr) begin
          failures++;
          $display("FAIL %s_addr t=%0d got %h want %h", tag, t, mem_addr, e.addr);
        end
      end
    end
  endtask

  task automatic test_random_jobs();
    obs_t e;
    int L, T;
    logic [ABW-1:0] w, a;
    for (int j = 0; j < 20; j++) begin
      L = (j % 5 == 0) ? 0 : $urandom_range(1, 12);
      w = ABW'($urandom); a = ABW'($urandom);
      T = job_len(L);
      @(negedge clk);
      len = LBW'(L); w_base = w; a_base = a; start = 1'b1;
      for (int t = 1; t <= T + 1; t++) begin
        @(negedge clk);
        // Noise on inputs and stray start pulses while the job is running.
        start = (t <= T) ? 1'($urandom) : 1'b0;
        len = LBW'($urandom); w_base = ABW'($urandom); a_base = ABW'($urandom);
        e = model(t, L, w, a);
        checks++;
        if ({mem_cen, inst_w, busy, done} !== {e.cen, e.inst, e.busy, e.done}) begin
          failures++;
          $display("FAIL rand_ctl job=%0d len=%0d t=%0d got cen=%b inst=%b busy=%b done=%b want %b %b %b %b",
                   j, L, t, mem_cen, inst_w, busy, done, e.cen, e.inst, e.busy, e.done);
        end
        if (!e.cen) begin
          checks++;
          if (mem_addr !== e.addr) begin
            failures++;
            $display("FAIL rand_addr job=%0d t=%0d got %h want %h", j, t, mem_addr, e.addr);
          end
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    int dones = 0;
    int T = job_len(4);
    @(negedge clk);
    len = 8'd4; w_base = 11'h020; a_base = 11'h200; start = 1'b1;
    for (int t = 1; t <= T + 6; t++) begin
      @(negedge clk);
      start = (t == 2*COL + 2);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL ignored_start done_count got %0d want 1", dones);
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    int T1 = job_len(4);
    int T2 = job_len(3);
    @(negedge clk);
    len = 8'd4; w_base = 11'h040; a_base = 11'h300; start = 1'b1;
    for (int t = 1; t <= T1 + 1 + T2 + 1; t++) begin
      @(negedge clk);
      if (t == 5) begin
        len = 8'd3; w_base = 11'h050; a_base = 11'h310;
      end
      if (t == T1 + 2) start = 1'b0;
      e = (t <= T1 + 1) ? model(t, 4, 11'h040, 11'h300)
                        : model(t - (T1 + 1), 3, 11'h050, 11'h310);
      checks++;
      if ({mem_cen, inst_w, busy, done} !== {e.cen, e.inst, e.busy, e.done}) begin
        failures++;
        $display("FAIL b2b_ctl t=%0d got cen=%b inst=%b busy=%b done=%b want %b %b %b %b",
                 t, mem_cen, inst_w, busy, done, e.cen, e.inst, e.busy, e.done);
      end
      if (!e.cen) begin
        checks++;
        if (mem_addr !== e.addr) begin
          failures++;
          $display("FAIL b2b_addr t=%0d got %h want %h", t, mem_addr, e.addr);
        end
      end
    end
  endtask

  task automatic test_reset_mid_job();
    int dones = 0;
    @(negedge clk);
    len = 8'd6; w_base = 11'h0A0; a_base = 11'h1C0; start = 1'b1;
    // Cycle 2*COL+3 is the third EXEC cycle (cnt == 2).
    for (int t = 1; t <= 2*COL + 3; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (mem_addr !== 11'h1C2 || mem_cen !== 1'b0) begin
      failures++;
      $display("FAIL midreset_pre got cen=%b addr=%h want 0 1c2", mem_cen, mem_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({mem_cen, inst_w, busy, done} !== {1'b1, 2'b00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_post got cen=%b inst=%b busy=%b done=%b want 1 00 0 0",
               mem_cen, inst_w, busy, done);
    end
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL midreset_quiet got %0d busy/done cycles want 0", dones);
    end
    test_basic("after_reset", 4, 11'h010, 11'h100);
  endtask

  task automatic test_addr_wrap();
    logic [ABW-1:0] got[$];
    logic [ABW-1:0] want[$];
    want = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    @(negedge clk);
    len = 8'd4; w_base = 11'h7FC; a_base = 11'h7FE; start = 1'b1;
    for (int t = 1; t <= job_len(4) + 1; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t > 2*COL && mem_cen === 1'b0) got.push_back(mem_addr);
    end
    checks++;
    if (got.size() != 4) begin
      failures++;
      $display("FAIL wrap_count got %0d exec reads want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          failures++;
          $display("FAIL wrap_addr idx=%0d got %h want %h", i, got[i], want[i]);
        end
      end
    end
  endtask

`ifdef SYS_CTRL_PERF_EN
  task automatic test_perf();
    int T = job_len(4);
    do_reset();
    checks++;
    if (perf_cycles !== 32'd0 || perf_jobs !== 16'd0) begin
      failures++;
      $display("FAIL perf_reset got cycles=%0d jobs=%0d want 0 0", perf_cycles, perf_jobs);
    end
    @(negedge clk);
    len = 8'd4; w_base = 11'h010; a_base = 11'h100; start = 1'b1;
    for (int t = 1; t <= 2*T + 2; t++) begin
      @(negedge clk);
      if (t == T + 2) start = 1'b0;
    end
    checks++;
    if (perf_jobs !== 16'd2) begin
      failures++;
      $display("FAIL perf_jobs got %0d want 2", perf_jobs);
    end
    checks++;
    if (perf_cycles !== 32'(2 * T)) begin
      failures++;
      $display("FAIL perf_cycles got %0d want %0d", perf_cycles, 2 * T);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic("basic", 4, 11'h010, 11'h100);
    test_basic("len0", 0, 11'h123, 11'h456);
    test_random_jobs();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_job();
    test_addr_wrap();
`ifdef SYS_CTRL_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
